// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: configuration shadowing, frame-activity tracking and receive
// buffering around a UART receiver.
//  - New settings are held in a shadow copy and reach the receiver only while
//    the line is idle, so a frame is never received with mixed settings.
//  - A watchdog ends a frame whose Rx_valid pulse never arrives.
//  - Received words go into a first-word-fall-through FIFO with a sticky overrun flag.
module uart_rx_ctrl #(
   parameter int         DATA_WIDTH   = 8,
   parameter int         FIFO_DEPTH   = 4,
   parameter int         GUARD_CYC    = 4,
   parameter logic [3:0] PRESCALE_RST = 4'd8
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          RX_IN,
   input  logic                          Cfg_wr,
   input  logic [3:0]                    Cfg_prescale,
   input  logic                          Cfg_parity_en,
   input  logic                          Cfg_parity_type,
   output logic [3:0]                    Prescale,
   output logic                          Parity_EN,
   output logic                          Parity_type,
   output logic                          Cfg_pending,
   input  logic [DATA_WIDTH-1:0]         Rx_data,
   input  logic                          Rx_valid,
   output logic [DATA_WIDTH-1:0]         Rd_data,
   output logic                          Rd_valid,
   input  logic                          Rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   Fifo_count,
   output logic                          Overrun,
   input  logic                          Ovr_clr,
   output logic                          Busy
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;
   // Watchdog sized for the worst case: prescale 15, parity enabled.
   localparam int WD_W = $clog2(15 * (DATA_WIDTH + 4) + 1);
   localparam int GD_W = $clog2(GUARD_CYC + 1);
   localparam logic [WD_W-1:0] WD_ONE = 1;

   typedef enum logic [1:0] {IDLE, FRAME, GUARD} state_t;

   state_t state, state_nxt;

   logic [WD_W-1:0] wd_cnt;
   logic [WD_W-1:0] wd_frame_bits;
   logic [WD_W-1:0] wd_limit;
   logic            wd_last;
   logic [GD_W-1:0] guard_cnt;
   logic            guard_last;

   logic [3:0]      sh_prescale;
   logic            sh_parity_en;
   logic            sh_parity_type;
   logic            cfg_accept;
   logic            cfg_apply;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  drop;

   // Frame length in clocks for the active settings; the watchdog fires on its last cycle.
   assign wd_frame_bits = WD_W'(DATA_WIDTH + 3) + WD_W'(Parity_EN);
   assign wd_limit      = WD_W'(Prescale) * wd_frame_bits;
   assign wd_last       = (wd_cnt == (wd_limit - WD_ONE));
   assign guard_last    = (guard_cnt == GD_W'(GUARD_CYC - 1));

   // Next-state logic: start edge opens a frame, word or watchdog closes it,
   // and a run of idle-high cycles returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!RX_IN) state_nxt = FRAME;
         FRAME:   if (Rx_valid || wd_last) state_nxt = GUARD;
         GUARD:   if (RX_IN && guard_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register with Busy registered alongside it.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         Busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         Busy  <= (state_nxt != IDLE);
      end
   end

   // Watchdog: clocks spent in FRAME, cleared in every other state.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wd_cnt <= '0;
      end else if (state != FRAME) begin
         wd_cnt <= '0;
      end else if (!wd_last) begin
         wd_cnt <= wd_cnt + WD_ONE;
      end
   end

   // Guard counter: consecutive high cycles in GUARD; any low sample restarts it.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         guard_cnt <= '0;
      end else if ((state != GUARD) || !RX_IN) begin
         guard_cnt <= '0;
      end else if (!guard_last) begin
         guard_cnt <= guard_cnt + GD_W'(1);
      end
   end

   // A fresh write takes precedence over a commit in the same cycle, so the
   // newest settings are the ones that reach the receiver.
   assign cfg_accept = Cfg_wr && (Cfg_prescale != 4'd0);
   assign cfg_apply  = (state == IDLE) && Cfg_pending && RX_IN && !cfg_accept;

   // Shadow and active configuration; active only changes at a quiet-line commit.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         sh_prescale    <= PRESCALE_RST;
         sh_parity_en   <= 1'b0;
         sh_parity_type <= 1'b0;
         Prescale       <= PRESCALE_RST;
         Parity_EN      <= 1'b0;
         Parity_type    <= 1'b0;
         Cfg_pending    <= 1'b0;
      end else if (cfg_accept) begin
         sh_prescale    <= Cfg_prescale;
         sh_parity_en   <= Cfg_parity_en;
         sh_parity_type <= Cfg_parity_type;
         Cfg_pending    <= 1'b1;
      end else if (cfg_apply) begin
         Prescale       <= sh_prescale;
         Parity_EN      <= sh_parity_en;
         Parity_type    <= sh_parity_type;
         Cfg_pending    <= 1'b0;
      end
   end

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign full     = (count == CW'(FIFO_DEPTH));
   assign Rd_valid = (count != '0);
   assign pop      = Rd_valid && Rd_ready;
   assign push     = Rx_valid && (!full || pop);
   assign drop     = Rx_valid && full && !pop;

   assign Fifo_count = count;
   assign Rd_data    = Rd_valid ? mem[rd_ptr] : '0;

   // Storage array; contents are only meaningful between rd_ptr and wr_ptr.
   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr] <= Rx_data;
   end

   // Pointers, occupancy and sticky overrun (a drop beats a clear).
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         Overrun <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop)         Overrun <= 1'b1;
         else if (Ovr_clr) Overrun <= 1'b0;
      end
   end

endmodule
